// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input path: default sample width,
// frame-order mode encodings and the ping-pong bank state.
package fft_pkg;

  localparam int DEF_DATA_W = 34;

  localparam logic MODE_STRIDED = 1'b0;
  localparam logic MODE_NATURAL = 1'b1;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_st_e;

endpackage

// File: rtl/s_p_reorder_if.sv
// Serial-in / parallel-out handshake bundle of the reorder buffer.
// The slave modport is the buffer itself, master is its environment.
interface s_p_reorder_if #(
  parameter int DATA_W = fft_pkg::DEF_DATA_W,
  parameter int LANES  = 4
);

  logic [DATA_W-1:0]       in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic                    mode;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_first;
  logic                    out_last;
  logic                    frame_err;

  modport master (
    output in_data, in_valid, in_last, mode, out_ready,
    input  in_ready, out_data, out_valid, out_first, out_last, frame_err
  );

  modport slave (
    input  in_data, in_valid, in_last, mode, out_ready,
    output in_ready, out_data, out_valid, out_first, out_last, frame_err
  );

endinterface

// File: rtl/s_p_reorder_bank.sv
// One ping-pong bank: frame storage, the order mode latched with sample 0,
// and the lane mux that assembles output word k (with write bypass).
module s_p_bank import fft_pkg::*; #(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int N_PTS   = 16,
  parameter int LANES   = 4,
  localparam int S      = N_PTS / LANES,
  localparam int IDX_W  = $clog2(N_PTS),
  localparam int RIDX_W = (S > 1) ? $clog2(S) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic                    mode_we_i,
  input  logic                    mode_i,
  input  logic [RIDX_W-1:0]       k_i,
  output logic [LANES*DATA_W-1:0] word_o
);

  logic [DATA_W-1:0] mem_q [N_PTS];
  logic              mode_q;
  logic              mode_s;

  function automatic logic [IDX_W-1:0] lane_addr(input logic nat,
                                                 input logic [RIDX_W-1:0] k,
                                                 input int j);
    int a;
    if (nat == MODE_NATURAL) a = int'(k) * LANES + j;
    else                     a = int'(k) + j * S;
    return a[IDX_W-1:0];
  endfunction

  // Order mode of the frame currently held in this bank.
  always_ff @(posedge clk) begin
    if (rst)            mode_q <= MODE_STRIDED;
    else if (mode_we_i) mode_q <= mode_i;
    else                mode_q <= mode_q;
  end

  // Sample storage.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // The sample being written this cycle is forwarded so word 0 can be
  // registered on the same edge that completes the frame.
  always_comb begin
    mode_s = mode_we_i ? mode_i : mode_q;
    word_o = '0;
    for (int j = 0; j < LANES; j++) begin
      if (we_i && (waddr_i == lane_addr(mode_s, k_i, j)))
        word_o[j*DATA_W +: DATA_W] = wdata_i;
      else
        word_o[j*DATA_W +: DATA_W] = mem_q[lane_addr(mode_s, k_i, j)];
    end
  end

endmodule

// File: rtl/s_p_reorder.sv
// Serial-to-parallel reorder buffer at the FFT input: two ping-pong banks,
// per-bank state machines and a registered, backpressurable output word.
module s_p_reorder import fft_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N_PTS  = 16,
  parameter int LANES  = 4
) (
  input logic          clk,
  input logic          rst,
  s_p_reorder_if.slave bus
);

  localparam int S      = N_PTS / LANES;
  localparam int IDX_W  = $clog2(N_PTS);
  localparam int RIDX_W = (S > 1) ? $clog2(S) : 1;
  localparam logic [IDX_W-1:0]  WR_LAST = IDX_W'(N_PTS - 1);
  localparam logic [RIDX_W-1:0] RD_LAST = RIDX_W'(S - 1);

  bank_st_e                bank_st_q [2];
  bank_st_e                bank_st_d [2];
  logic                    wr_sel_q;
  logic                    rd_sel_q;
  logic [IDX_W-1:0]        wr_idx_q;
  logic [RIDX_W-1:0]       rd_idx_q;
  logic [LANES*DATA_W-1:0] out_data_q;
  logic                    out_valid_q;
  logic                    out_first_q;
  logic                    out_last_q;
  logic                    frame_err_q;

  logic                    in_ready_s;
  logic                    in_fire_s;
  logic                    out_fire_s;
  logic                    fill_done_s;
  logic                    drain_done_s;
  logic                    load_en_s;
  logic                    nxt_sel_s;
  logic [RIDX_W-1:0]       nxt_idx_s;
  logic                    nxt_avail_s;
  logic [LANES*DATA_W-1:0] bank_word_s [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    s_p_bank #(
      .DATA_W (DATA_W),
      .N_PTS  (N_PTS),
      .LANES  (LANES)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .we_i      (in_fire_s && (wr_sel_q == 1'(g))),
      .waddr_i   (wr_idx_q),
      .wdata_i   (bus.in_data),
      .mode_we_i (in_fire_s && (wr_sel_q == 1'(g)) && (wr_idx_q == '0)),
      .mode_i    (bus.mode),
      .k_i       (nxt_idx_s),
      .word_o    (bank_word_s[g])
    );
  end

  // Handshakes and the word the output register should hold next.
  always_comb begin
    in_ready_s   = !rst && ((bank_st_q[wr_sel_q] == EMPTY) ||
                            (bank_st_q[wr_sel_q] == FILLING));
    in_fire_s    = bus.in_valid && in_ready_s;
    out_fire_s   = out_valid_q && bus.out_ready;
    fill_done_s  = in_fire_s && (wr_idx_q == WR_LAST);
    drain_done_s = out_fire_s && (rd_idx_q == RD_LAST);
    load_en_s    = !out_valid_q || bus.out_ready;
    if (drain_done_s) begin
      nxt_sel_s = !rd_sel_q;
      nxt_idx_s = '0;
    end else if (out_fire_s) begin
      nxt_sel_s = rd_sel_q;
      nxt_idx_s = rd_idx_q + RIDX_W'(1);
    end else begin
      nxt_sel_s = rd_sel_q;
      nxt_idx_s = rd_idx_q;
    end
    // A bank completing this very cycle counts as readable.
    nxt_avail_s = (bank_st_q[nxt_sel_s] == FULL) ||
                  (bank_st_q[nxt_sel_s] == DRAINING) ||
                  (fill_done_s && (wr_sel_q == nxt_sel_s));
  end

  // Per-bank state transitions; both banks may move in the same cycle.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_st_d[b] = bank_st_q[b];
      case (bank_st_q[b])
        EMPTY: begin
          if (in_fire_s && (wr_sel_q == 1'(b))) bank_st_d[b] = FILLING;
          else                                   bank_st_d[b] = EMPTY;
        end
        FILLING: begin
          if (fill_done_s && (wr_sel_q == 1'(b))) bank_st_d[b] = FULL;
          else                                     bank_st_d[b] = FILLING;
        end
        FULL: begin
          if (drain_done_s && (rd_sel_q == 1'(b)))     bank_st_d[b] = EMPTY;
          else if (out_fire_s && (rd_sel_q == 1'(b)))  bank_st_d[b] = DRAINING;
          else                                         bank_st_d[b] = FULL;
        end
        DRAINING: begin
          if (drain_done_s && (rd_sel_q == 1'(b))) bank_st_d[b] = EMPTY;
          else                                      bank_st_d[b] = DRAINING;
        end
        default: bank_st_d[b] = EMPTY;
      endcase
    end
  end

  // Bank states, pointers, error pulse and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) bank_st_q[b] <= EMPTY;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) bank_st_q[b] <= bank_st_d[b];
      if (fill_done_s) begin
        wr_sel_q <= !wr_sel_q;
        wr_idx_q <= '0;
      end else if (in_fire_s) begin
        wr_idx_q <= wr_idx_q + IDX_W'(1);
      end
      if (out_fire_s) begin
        rd_sel_q <= nxt_sel_s;
        rd_idx_q <= nxt_idx_s;
      end
      frame_err_q <= in_fire_s && (bus.in_last != (wr_idx_q == WR_LAST));
      if (load_en_s) begin
        out_valid_q <= nxt_avail_s;
        if (nxt_avail_s) begin
          out_data_q  <= bank_word_s[nxt_sel_s];
          out_first_q <= (nxt_idx_s == '0);
          out_last_q  <= (nxt_idx_s == RD_LAST);
        end else begin
          out_first_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_first = out_first_q;
  assign bus.out_last  = out_last_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_s_p_reorder.sv
// Directed bench for s_p_reorder: a frame-level queue model checked every
// cycle, plus hand-computed words pinning strided/natural ordering.
module tb_s_p_reorder;

  localparam int DW = 34;
  localparam int NP = 16;
  localparam int LN = 4;
  localparam int S  = NP / LN;
  localparam int WW = LN * DW;

  typedef struct {
    logic [WW-1:0] data;
    logic          first;
    logic          last;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  s_p_reorder_if #(.DATA_W(DW), .LANES(LN)) bus ();

  s_p_reorder #(.DATA_W(DW), .N_PTS(NP), .LANES(LN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            total = 0;
  int            bad   = 0;
  int            ferr_cnt = 0;
  int            cyc = 0;
  word_t         exp_q [$];
  logic [DW-1:0] part_q [$];
  logic          part_mode = 1'b0;
  logic          ferr_e = 1'b0;
  logic [WW-1:0] xlog [$];

  task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [WW-1:0] pack4(input int d3, input int d2, input int d1, input int d0);
    return {DW'(d3), DW'(d2), DW'(d1), DW'(d0)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a frame becomes S expected words once its N-th sample is taken;
  // banks held = complete frames not yet fully transferred.
  always @(negedge clk) begin
    word_t w;
    logic  rdy_e;
    logic  vld_e;
    logic  acc;
    if (rst) begin
      chk("in_ready_during_reset", WW'(bus.in_ready), '0);
      exp_q.delete();
      part_q.delete();
      ferr_e = 1'b0;
    end else begin
      rdy_e = ((exp_q.size() + S - 1) / S) < 2;
      vld_e = exp_q.size() > 0;
      chk("in_ready", WW'(bus.in_ready), WW'(rdy_e));
      chk("out_valid", WW'(bus.out_valid), WW'(vld_e));
      chk("frame_err", WW'(bus.frame_err), WW'(ferr_e));
      if (bus.frame_err) ferr_cnt++;
      if (vld_e) begin
        chk("out_data", bus.out_data, exp_q[0].data);
        chk("out_first", WW'(bus.out_first), WW'(exp_q[0].first));
        chk("out_last", WW'(bus.out_last), WW'(exp_q[0].last));
        if (bus.out_ready) begin
          xlog.push_back(bus.out_data);
          exp_q.delete(0);
        end
      end
      acc    = bus.in_valid && rdy_e;
      ferr_e = acc && (bus.in_last != (part_q.size() == NP - 1));
      if (acc) begin
        if (part_q.size() == 0) part_mode = bus.mode;
        part_q.push_back(bus.in_data);
        if (part_q.size() == NP) begin
          for (int k = 0; k < S; k++) begin
            w.data = '0;
            for (int j = 0; j < LN; j++)
              w.data[j*DW +: DW] = part_mode ? part_q[k*LN + j] : part_q[k + j*S];
            w.first = (k == 0);
            w.last  = (k == S - 1);
            exp_q.push_back(w);
          end
          part_q.delete();
        end
      end
    end
  end

  task automatic send(input int d, input logic l, input logic m);
    int   n;
    logic a;
    bus.in_data  = DW'(d);
    bus.in_last  = l;
    bus.mode     = m;
    bus.in_valid = 1'b1;
    n = 0;
    a = 1'b0;
    while (!a && n < 300) begin
      @(negedge clk);
      a = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accepted", WW'(a), WW'(1));
  endtask

  task automatic send_frame(input int base, input logic m, input int last_pos);
    for (int i = 0; i < NP; i++) send(base + i, (i == NP - 1) || (i == last_pos), m);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_complete", WW'(exp_q.size()), '0);
  endtask

  initial begin
    int n0;
    int c0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", WW'(bus.out_valid), '0);
    chk("reset_out_data", bus.out_data, '0);
    chk("reset_out_first", WW'(bus.out_first), '0);
    chk("reset_out_last", WW'(bus.out_last), '0);
    chk("reset_frame_err", WW'(bus.frame_err), '0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Strided single frame
    n0 = xlog.size();
    send_frame(0, 1'b0, -1);
    idle();
    chk("latency_valid", WW'(bus.out_valid), WW'(1));
    wait_drain();
    chk("strided_w0", xlog[n0],   pack4(12, 8, 4, 0));
    chk("strided_w1", xlog[n0+1], pack4(13, 9, 5, 1));
    chk("strided_w2", xlog[n0+2], pack4(14, 10, 6, 2));
    chk("strided_w3", xlog[n0+3], pack4(15, 11, 7, 3));

    // Natural order
    n0 = xlog.size();
    send_frame(0, 1'b1, -1);
    idle();
    wait_drain();
    chk("natural_w0", xlog[n0],   pack4(3, 2, 1, 0));
    chk("natural_w1", xlog[n0+1], pack4(7, 6, 5, 4));
    chk("natural_w3", xlog[n0+3], pack4(15, 14, 13, 12));

    // Backpressure held on word 1
    n0 = xlog.size();
    bus.out_ready = 1'b0;
    send_frame(0, 1'b0, -1);
    idle();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", bus.out_data, pack4(13, 9, 5, 1));
      chk("bp_hold_valid", WW'(bus.out_valid), WW'(1));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_drain();
    chk("bp_w0", xlog[n0],   pack4(12, 8, 4, 0));
    chk("bp_w1", xlog[n0+1], pack4(13, 9, 5, 1));
    chk("bp_w2", xlog[n0+2], pack4(14, 10, 6, 2));
    chk("bp_w3", xlog[n0+3], pack4(15, 11, 7, 3));

    // Ping-pong with both banks full
    n0 = xlog.size();
    bus.out_ready = 1'b0;
    send_frame(200, 1'b0, -1);
    send_frame(216, 1'b0, -1);
    fork
      send_frame(232, 1'b0, -1);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          chk("pp_full_in_ready", WW'(bus.in_ready), '0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    idle();
    wait_drain();
    chk("pp_f0_w0", xlog[n0],   pack4(212, 208, 204, 200));
    chk("pp_f1_w0", xlog[n0+4], pack4(228, 224, 220, 216));
    chk("pp_f2_w3", xlog[n0+11], pack4(247, 243, 239, 235));

    // Continuous streaming, 48 samples with no stall
    c0 = cyc;
    send_frame(300, 1'b0, -1);
    send_frame(316, 1'b1, -1);
    send_frame(332, 1'b0, -1);
    chk("stream_cycles", WW'(cyc - c0), WW'(48));
    idle();
    wait_drain();

    // Framing error on sample 9
    n0 = xlog.size();
    ferr_cnt = 0;
    send_frame(400, 1'b0, 9);
    idle();
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    chk("frame_err_pulses", WW'(ferr_cnt), WW'(1));
    chk("ferr_frame_w0", xlog[n0], pack4(412, 408, 404, 400));

    // Reset after 7 samples
    for (int i = 0; i < 7; i++) send(500 + i, 1'b0, 1'b0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_reset_in_ready", WW'(bus.in_ready), '0);
    chk("mid_reset_out_valid", WW'(bus.out_valid), '0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", WW'(bus.out_valid), '0);
    chk("post_reset_in_ready", WW'(bus.in_ready), WW'(1));
    @(posedge clk);
    #1;
    n0 = xlog.size();
    send_frame(600, 1'b0, -1);
    idle();
    wait_drain();
    chk("post_reset_w0", xlog[n0], pack4(612, 608, 604, 600));
    chk("post_reset_w3", xlog[n0+3], pack4(615, 611, 607, 603));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/s_p_reorder.md
Name: s_p_reorder

Overview:
- Parametrised serial-to-parallel converter and reorder buffer at the FFT input.
- Accepts one complex sample per cycle and emits LANES samples per output word.
- Output order is either stride-S (radix-LANES first-stage order, S = N_PTS/LANES) or natural order, selected per frame.
- Ping-pong banks let frame n+1 fill while frame n drains. Valid/ready handshakes on both sides replace the fixed-timing flag pulses.

Parameters:
- DATA_W, 34, bits per complex sample (re/im packed).
- N_PTS, 16, samples per frame; power of 2, >= LANES.
- LANES, 4, samples per output word; power of 2, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_data  in  DATA_W  serial sample.
- in_valid  in  1  sample present.
- in_ready  out  1  buffer can accept a sample.
- in_last  in  1  marks the last sample of a frame; checked only, not used for framing.
- mode  in  1  0 = strided, 1 = natural; sampled with the first sample of each frame.
- out_data  out  LANES*DATA_W  parallel word; lane 0 in LSBs.
- out_valid  out  1  word present.
- out_ready  in  1  consumer accepts the word.
- out_first  out  1  high with word 0 of a frame.
- out_last  out  1  high with word S-1 of a frame.
- frame_err  out  1  one-cycle pulse on an in_last mismatch.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Reset values: out_valid=0, out_data=0, out_first=0, out_last=0, frame_err=0, both banks EMPTY, all pointers 0.
- in_ready=0 while rst is high; in_ready=1 from the first cycle after release.
- Bank states: EMPTY -> FILLING on the first accepted sample; FILLING -> FULL on sample N_PTS-1; FULL -> DRAINING on the first output transfer; DRAINING -> EMPTY on the transfer of word S-1.
- A bank also goes FULL -> EMPTY directly when S=1.
- Write side: fills the bank selected by wr_sel, then toggles wr_sel.
- Read side: drains the bank selected by rd_sel, then toggles rd_sel.
- in_ready = bank[wr_sel] is EMPTY or FILLING, using registered state.
- A bank released to EMPTY in cycle t is writable from cycle t+1. No same-cycle reuse.
- Strided word k (mode=0), k = 0..S-1: lane j holds sample x[k + j*S].
  - Example (N_PTS=16, LANES=4): word0 = {x12,x8,x4,x0}, word3 = {x15,x11,x7,x3}.
- Natural word k (mode=1): lane j holds x[k*LANES + j].
- Mode is latched per bank at the first sample. A mode change mid-frame has no effect until the next frame.
- Latency: out_valid rises the cycle after sample N_PTS-1 of a frame is accepted, provided the read bank is that bank.
- Output registers: out_data, out_valid, out_first and out_last are registered.
- Backpressure: while out_valid && !out_ready, all outputs hold stable.
- Throughput: with out_ready=1 continuously, back-to-back frames stream with in_ready never deasserting, since a drain takes S <= N_PTS cycles.
- Both banks FULL: in_ready=0 until the read bank reaches EMPTY.
- Framing is count-based: a frame is always exactly N_PTS accepted samples.
- frame_err pulses the cycle after an accepted sample where in_last != (wr_idx == N_PTS-1). The data path is unaffected.
- Reset mid-operation: the partial frame and any buffered frames are discarded, and out_valid drops the next cycle.
- Simultaneous last write and last read (different banks): both state updates occur in the same cycle. Each bank transitions independently.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_W default (34);
  - mode encodings MODE_STRIDED=0 and MODE_NATURAL=1;
  - bank state enum {EMPTY, FILLING, FULL, DRAINING}.
- Sub-module s_p_bank holds one bank: N_PTS x DATA_W storage, latched mode, and the strided/natural read mux for word index k. It is instantiated twice.
- The top level owns the bank FSMs, wr_sel/rd_sel, wr_idx/rd_idx counters and the output register.

Test Plan:
- Strided, single frame: mode=0, in_data=0..15 with in_valid=1, out_ready=1 -> four words {12,8,4,0}, {13,9,5,1}, {14,10,6,2}, {15,11,7,3}. out_first on word 0, out_last on word 3, first out_valid one cycle after sample 15.
- Natural mode: mode=1, same input -> {3,2,1,0}, {7,6,5,4}, {11,10,9,8}, {15,14,13,12}.
- Backpressure: out_ready=0 for 5 cycles at word 1 -> out_data stays {13,9,5,1} and out_valid stays 1. The remaining words arrive unchanged and in order.
- Ping-pong / full: 48 samples offered continuously with out_ready=0 -> in_ready drops after 32 accepted. Raising out_ready resumes input after the first bank empties. With out_ready=1 throughout, in_ready stays 1 for all 48 samples.
- Framing error: in_last asserted on sample 9 -> frame_err pulses once. The frame still completes after 16 samples with correct output.
- Reset mid-frame: rst for 1 cycle after 7 samples -> out_valid=0 and in_ready=0 during reset. The next 16 samples form a clean frame with word0 = those samples' {x12,x8,x4,x0}.
